aes192_key_sched_ctrl: RTL and testbench
========================================

AES192_KEY_SCHED_CTRL -- requirements
Module: aes192_key_sched_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; port and signal widths are as listed below, with no parameters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  single-cycle request to expand key_in; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of an expansion in progress.
REQ-006 key_in  input  192  cipher key, bit 0 = MSB; word w[k] = key_in[32k +: 32], k = 0..5.
REQ-007 busy  output  1  high from the edge accepting start until return to IDLE.
REQ-008 rk_valid  output  1  rk_data/rk_idx hold a complete round key.
REQ-009 rk_ready  input  1  consumer accepts the round key when rk_valid && rk_ready at a rising edge.
REQ-010 rk_data  output  128  round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] at bits [0:31].
REQ-011 rk_idx  output  4  round index r, 0..12.
REQ-012 done  output  1  one-cycle pulse after round key 12 is accepted.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and FLUSH; IDLE->RUN on start, RUN->FLUSH when word 51 is appended, FLUSH->IDLE on acceptance of round 12.
REQ-014 On start in IDLE, the block SHALL load a 6-word window with key_in, clear word index n and the output buffer, and set busy.
REQ-015 In RUN, the block SHALL append at most one word per cycle to the 4-word output buffer, in order n = 0..51.
REQ-016 For n < 6, the appended word SHALL be window[n], with no window shift.
REQ-017 For n >= 6, the appended word SHALL be w[n] = w[n-6] ^ t, and the window SHALL shift by one.
REQ-018 t SHALL be SubWord(RotWord(w[n-1])) ^ Rcon(n/6) when n % 6 == 0, and w[n-1] otherwise.
REQ-019 RotWord SHALL rotate left one byte; SubWord SHALL apply the AES S-box to each byte.
REQ-020 Rcon(j) SHALL be {rc, 24'h0}, with rc = 01, 02, 04, 08, 10, 20, 40, 80 for j = 1..8.
REQ-021 Exactly one 4-byte SubWord instance SHALL exist, used only on cycles where n % 6 == 0.
REQ-022 rk_valid SHALL rise on the edge that appends the fourth word of a round key.
REQ-023 While rk_valid && !rk_ready, word generation SHALL stall, and rk_data, rk_idx and n SHALL hold.
REQ-024 On a handshake edge, the buffer SHALL empty and the same edge SHALL append the next word (zero-bubble), so one round key is produced per 4 cycles with no backpressure.
REQ-025 Timing: start accepted at edge E0; round key r valid after edge E(4r+4); with rk_ready held high, round 12 is accepted at E53 and done is high in the cycle after E53.
REQ-026 start while busy SHALL be ignored.
REQ-027 start and abort in the same IDLE cycle SHALL be treated as start ignored.
REQ-028 abort in RUN or FLUSH SHALL return the block to IDLE at the next edge: rk_valid and busy low, buffer cleared, no done pulse.
REQ-029 rk_idx SHALL wrap nowhere; after round 12 the FSM is in IDLE, and rk_valid SHALL never assert with rk_idx > 12.
REQ-030 key_in changes after start SHALL NOT affect the current expansion.

Reset
REQ-031 When rst_n is low, the block SHALL immediately enter IDLE with busy = 0, rk_valid = 0, done = 0, rk_data = 0, rk_idx = 0, n = 0 and the window cleared, including mid-expansion.
REQ-032 After rst_n deasserts, the first start SHALL be honoured on the first rising edge.

Verification
REQ-033 Start with key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b and rk_ready = 1 -> rk0 = 8e73b0f7da0e6452c810f32b809079e5, rk1 = 62f8ead2522c6b7bfe0c91f72402f5a5, rk12 = e98ba06f448c773c8ecc720401002202; done one cycle after E53.
REQ-034 Same key with rk_ready low for 10 cycles at each rk_valid -> identical 13 keys, with data and index stable while stalled.
REQ-035 Second start pulsed while busy, with a different key -> output unchanged from REQ-033.
REQ-036 abort while rk_idx = 5 and rk_valid = 1 -> IDLE next edge, no done; a following start produces the full correct sequence.
REQ-037 rst_n low mid-RUN -> all outputs 0 asynchronously; restart yields the REQ-033 results.
REQ-038 All-zero key -> rk1 = 0000000000000000 62636363 62636363 and rk12 matches the software model.

Source files
------------

// File: rtl/aes192_key_sched_ctrl.sv
// AES-192 key schedule controller: expands a 192-bit key into 13 round keys,
// streamed one 128-bit key at a time over a valid/ready handshake.
module aes192_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [191:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_e;

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  state_e      state_q;
  logic [31:0] win_q [6];
  logic [31:0] rkbuf_q [4];
  logic [2:0]  cnt_q;
  logic [5:0]  n_q;
  logic [2:0]  phase_q;
  logic [7:0]  rcon_q;
  logic [3:0]  idx_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  logic [31:0] rot_w;
  logic [31:0] sub_w;
  logic [31:0] word_d;
  logic        hs;
  logic        adv;

  assign hs  = valid_q && rk_ready;
  assign adv = (state_q == RUN) && (!valid_q || rk_ready);

  // Single SubWord; its result only matters when phase_q == 0.
  always_comb begin
    rot_w = {win_q[5][23:0], win_q[5][31:24]};
    sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    if (n_q < 6'd6) begin
      word_d = win_q[n_q[2:0]];
    end else if (phase_q == 3'd0) begin
      word_d = win_q[0] ^ sub_w ^ {rcon_q, 24'h0};
    end else begin
      word_d = win_q[0] ^ win_q[5];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < 6; i++) win_q[i] <= '0;
      for (int i = 0; i < 4; i++) rkbuf_q[i] <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      phase_q <= '0;
      rcon_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != IDLE) && (abort || ((state_q == FLUSH) && hs))) begin
        // Completion and cancel share the return path; only completion pulses done.
        state_q <= IDLE;
        for (int i = 0; i < 4; i++) rkbuf_q[i] <= '0;
        cnt_q   <= '0;
        idx_q   <= '0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= !abort;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              for (int i = 0; i < 6; i++) win_q[i] <= key_in[191 - 32*i -: 32];
              for (int i = 0; i < 4; i++) rkbuf_q[i] <= '0;
              cnt_q   <= '0;
              n_q     <= '0;
              phase_q <= '0;
              rcon_q  <= 8'h01;
              idx_q   <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
          RUN: begin
            if (adv) begin
              if (hs) begin
                rkbuf_q[0] <= word_d;
                for (int i = 1; i < 4; i++) rkbuf_q[i] <= '0;
                cnt_q   <= 3'd1;
                idx_q   <= idx_q + 4'd1;
                valid_q <= 1'b0;
              end else begin
                rkbuf_q[cnt_q[1:0]] <= word_d;
                cnt_q   <= cnt_q + 3'd1;
                valid_q <= (cnt_q == 3'd3);
              end
              n_q     <= n_q + 6'd1;
              phase_q <= (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
              if (n_q >= 6'd6) begin
                for (int i = 0; i < 5; i++) win_q[i] <= win_q[i+1];
                win_q[5] <= word_d;
                if (phase_q == 3'd0) rcon_q <= {rcon_q[6:0], 1'b0};
              end
              if (n_q == 6'd51) state_q <= FLUSH;
            end
          end
          FLUSH: begin
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy     = busy_q;
  assign rk_valid = valid_q;
  assign rk_data  = {rkbuf_q[0], rkbuf_q[1], rkbuf_q[2], rkbuf_q[3]};
  assign rk_idx   = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes192_key_sched_ctrl.sv
// Scoreboard bench for aes192_key_sched_ctrl: a GF(2^8)-derived reference key
// expansion fills an expected queue; a monitor checks every accepted round key.
module tb_aes192_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [191:0] key_in = '0;
  logic         rk_ready = 1'b0;
  logic         busy;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         done;

  aes192_key_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key_in(key_in),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_idx(rk_idx), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [191:0] KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
  } rk_t;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           rdy_mode = 0;
  int           stall_cnt = 0;
  rk_t          exp_q[$];
  rk_t          mon_e;
  logic [127:0] got [13];
  logic [7:0]   sb [256];
  logic [31:0]  ref_w [52];
  logic         done_pend = 1'b0;
  logic         stall_prev = 1'b0;
  logic [127:0] stall_data;
  logic [3:0]   stall_idx;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} >> (8 - n);
    return d[7:0];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [191:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) ref_w[i] = k[191 - 32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = ref_w[i-1];
      if (i % 6 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      ref_w[i] = ref_w[i-6] ^ t;
    end
  endtask

  task automatic push_exp(input logic [191:0] k, input int nr);
    rk_t e;
    expand(k);
    for (int r = 0; r < nr; r++) begin
      e.idx  = 4'(r);
      e.data = {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [191:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Pulses start for one edge, then scrambles key_in to show it is not re-read.
  task automatic do_start(input logic [191:0] k, output int c0);
    for (int r = 0; r < 13; r++) got[r] = 'x;
    @(posedge clk); #1;
    key_in = k;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    c0     = cyc;
    key_in = rand_key();
  endtask

  task automatic wait_done(input int limit, output int when);
    when = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done) begin
        when = cyc;
        break;
      end
    end
    if (when < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within %0d cycles, want done", limit);
    end
  endtask

  task automatic wait_valid(input int idx, input int limit);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (rk_valid && (idx < 0 || int'(rk_idx) == idx)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL valid_timeout: got no rk_valid for idx %0d, want it", idx);
    end
  endtask

  // Consumer model: always ready, random, 10-cycle stall per key, refuse round 5, or never.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: rk_ready = 1'b1;
      1: rk_ready = 1'($urandom_range(0, 1));
      2: begin
        if (!rk_valid) begin
          rk_ready  = 1'b0;
          stall_cnt = 0;
        end else if (stall_cnt == 10) begin
          rk_ready  = 1'b1;
          stall_cnt = 0;
        end else begin
          rk_ready  = 1'b0;
          stall_cnt = stall_cnt + 1;
        end
      end
      3: rk_ready = !(rk_valid && rk_idx == 4'd5);
      default: rk_ready = 1'b0;
    endcase
  end

  // Monitor: compares each accepted key against the queue, tracks done and stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_pend  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check("done", {127'd0, done}, {127'd0, done_pend});
      done_pend = 1'b0;
      if (stall_prev) begin
        check("stall_valid", {127'd0, rk_valid}, 128'd1);
        check("stall_data", rk_data, stall_data);
        check("stall_idx", {124'd0, rk_idx}, {124'd0, stall_idx});
      end
      stall_prev = rk_valid && !rk_ready && !abort;
      stall_data = rk_data;
      stall_idx  = rk_idx;
      if (rk_valid && rk_ready && !abort) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rk: got idx %0d data %h, want no key", rk_idx, rk_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("rk_idx", {124'd0, rk_idx}, {124'd0, mon_e.idx});
          check("rk_data", rk_data, mon_e.data);
        end
        if (rk_idx < 4'd13) got[rk_idx] = rk_data;
        if (rk_idx == 4'd12) done_pend = 1'b1;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {127'd0, busy}, 128'd0);
    check({tag, "_valid"}, {127'd0, rk_valid}, 128'd0);
    check({tag, "_done"}, {127'd0, done}, 128'd0);
    check({tag, "_data"}, rk_data, 128'd0);
    check({tag, "_idx"}, {124'd0, rk_idx}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int when;
    logic [191:0] k;

    build_sbox();
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reference vector with the consumer always ready.
    rdy_mode = 0;
    push_exp(KEY, 13);
    do_start(KEY, c0);
    check("busy_after_start", {127'd0, busy}, 128'd1);
    wait_done(200, when);
    check("done_latency", 128'(when - c0), 128'd53);
    check("busy_after_done", {127'd0, busy}, 128'd0);
    check("vec_rk0", got[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
    check("vec_rk1", got[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    check("vec_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);
    $display("run vector: done after %0d cycles", when - c0);

    // Ten-cycle stall at every key.
    rdy_mode = 2;
    push_exp(KEY, 13);
    do_start(KEY, c0);
    wait_done(1000, when);
    check("stall_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);
    $display("run stalled: done after %0d cycles", when - c0);

    // A second start with another key while busy must be ignored.
    rdy_mode = 0;
    push_exp(KEY, 13);
    do_start(KEY, c0);
    repeat (10) @(posedge clk);
    #1;
    start  = 1'b1;
    key_in = rand_key();
    @(posedge clk); #1;
    start  = 1'b0;
    wait_done(200, when);
    check("busy_start_latency", 128'(when - c0), 128'd53);
    check("busy_start_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);
    $display("run restart-while-busy: done after %0d cycles", when - c0);

    // Abort while round 5 is held, then a clean full run.
    rdy_mode = 3;
    push_exp(KEY, 5);
    do_start(KEY, c0);
    wait_valid(5, 200);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", {127'd0, busy}, 128'd0);
    check("abort_valid", {127'd0, rk_valid}, 128'd0);
    check("abort_data", rk_data, 128'd0);
    repeat (5) @(posedge clk);
    check("abort_drained", 128'(exp_q.size()), 128'd0);
    $display("run abort: returned to idle");
    rdy_mode = 0;
    push_exp(KEY, 13);
    do_start(KEY, c0);
    wait_done(200, when);
    check("post_abort_latency", 128'(when - c0), 128'd53);

    // Asynchronous reset mid-run, restart on the first edge after release.
    rdy_mode = 4;
    do_start(KEY, c0);
    wait_valid(-1, 50);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rdy_mode = 0;
    push_exp(KEY, 13);
    for (int r = 0; r < 13; r++) got[r] = 'x;
    rst_n  = 1'b1;
    key_in = KEY;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    c0     = cyc;
    check("first_start_busy", {127'd0, busy}, 128'd1);
    wait_done(200, when);
    check("post_reset_latency", 128'(when - c0), 128'd53);
    check("post_reset_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);
    $display("run after reset: done after %0d cycles", when - c0);

    // All-zero key.
    push_exp(192'd0, 13);
    do_start(192'd0, c0);
    wait_done(200, when);
    check("zero_rk1", got[1], 128'h00000000000000006263636362636363);
    check("zero_rk12", got[12], {ref_w[48], ref_w[49], ref_w[50], ref_w[51]});
    $display("run zero key: rk12 %h", got[12]);

    // Random keys with a random consumer.
    rdy_mode = 1;
    for (int t = 0; t < 4; t++) begin
      k = rand_key();
      push_exp(k, 13);
      do_start(k, c0);
      wait_done(2000, when);
      $display("run random %0d: key %h done after %0d cycles", t, k, when - c0);
    end

    repeat (3) @(posedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
